// File: rtl/arm_lsu_pkg.sv
// Shared constants for the load/store unit: FSM encodings, byte lanes, burst default.
package arm_lsu_pkg;

   localparam int unsigned BURST_MAX_DEF = 16;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RMW_WR = 2'd2;

   // Big-endian byte lanes selected by addr[1:0]
   localparam logic [1:0] LANE_31_24 = 2'd0;
   localparam logic [1:0] LANE_23_16 = 2'd1;
   localparam logic [1:0] LANE_15_8  = 2'd2;
   localparam logic [1:0] LANE_7_0   = 2'd3;

endpackage

// File: rtl/arm_byte_lane.sv
// Combinational byte-lane extract (zero-extended) and lane merge, big-endian.
module arm_byte_lane
   import arm_lsu_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [31:0] old_word,
   input  logic [1:0]  sel,
   input  logic [7:0]  new_byte,
   output logic [31:0] ext_c,
   output logic [31:0] merge_c
);

   // Pick the addressed lane out of rd_word and splice new_byte into old_word
   always_comb begin
      ext_c   = '0;
      merge_c = old_word;
      case (sel)
         LANE_31_24: begin ext_c = {24'd0, rd_word[31:24]}; merge_c[31:24] = new_byte; end
         LANE_23_16: begin ext_c = {24'd0, rd_word[23:16]}; merge_c[23:16] = new_byte; end
         LANE_15_8:  begin ext_c = {24'd0, rd_word[15:8]};  merge_c[15:8]  = new_byte; end
         default:    begin ext_c = {24'd0, rd_word[7:0]};   merge_c[7:0]   = new_byte; end
      endcase
   end

endmodule

// File: rtl/arm_lsu.sv
// Load/store unit: word, byte and block requests turned into word-granular memory beats.
module arm_lsu
   import arm_lsu_pkg::*;
#(
   parameter  int unsigned BURST_MAX = BURST_MAX_DEF,
   localparam int unsigned CW        = $clog2(BURST_MAX)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_store,
   input  logic          req_byte,
   input  logic [31:0]   req_addr,
   input  logic [CW-1:0] req_count,
   input  logic [31:0]   req_wdata,
   output logic [CW-1:0] beat_idx,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          mem_we,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_excpt,
   output logic          rsp_valid,
   output logic [CW-1:0] rsp_idx,
   output logic [31:0]   rsp_data,
   output logic          rsp_fault,
   output logic          rsp_last
);

   logic [1:0]    state_q, state_d;
   logic          store_q, store_d;
   logic          byte_q, byte_d;
   logic [31:0]   base_q, base_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] beat_q, beat_d;
   logic [31:0]   rmw_q, rmw_d;
   logic          rsp_valid_d, rsp_fault_d, rsp_last_d;
   logic [CW-1:0] rsp_idx_d;
   logic [31:0]   rsp_data_d;
   logic [31:0]   beat_addr;
   logic [31:0]   lane_ext, lane_merge;

   assign beat_idx  = beat_q;
   assign req_ready = (state_q == ST_IDLE);
   assign beat_addr = {base_q[31:2], 2'b00} + 32'({beat_q, 2'b00});

   arm_byte_lane u_lane (
      .rd_word  (mem_rdata),
      .old_word (rmw_q),
      .sel      (base_q[1:0]),
      .new_byte (req_wdata[7:0]),
      .ext_c    (lane_ext),
      .merge_c  (lane_merge)
   );

   // State and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         store_q   <= 1'b0;
         byte_q    <= 1'b0;
         base_q    <= '0;
         cnt_q     <= '0;
         beat_q    <= '0;
         rmw_q     <= '0;
         rsp_valid <= 1'b0;
         rsp_idx   <= '0;
         rsp_data  <= '0;
         rsp_fault <= 1'b0;
         rsp_last  <= 1'b0;
      end else begin
         state_q   <= state_d;
         store_q   <= store_d;
         byte_q    <= byte_d;
         base_q    <= base_d;
         cnt_q     <= cnt_d;
         beat_q    <= beat_d;
         rmw_q     <= rmw_d;
         rsp_valid <= rsp_valid_d;
         rsp_idx   <= rsp_idx_d;
         rsp_data  <= rsp_data_d;
         rsp_fault <= rsp_fault_d;
         rsp_last  <= rsp_last_d;
      end
   end

   // Next-state, memory-port decode and per-beat response
   always_comb begin
      state_d     = state_q;
      store_d     = store_q;
      byte_d      = byte_q;
      base_d      = base_q;
      cnt_d       = cnt_q;
      beat_d      = beat_q;
      rmw_d       = rmw_q;
      rsp_valid_d = 1'b0;
      rsp_idx_d   = '0;
      rsp_data_d  = '0;
      rsp_fault_d = 1'b0;
      rsp_last_d  = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_we      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if ((!req_byte && (req_addr[1:0] != 2'b00)) || (req_byte && (req_count != '0))) begin
                  // Misaligned or illegal: fault immediately, never touch memory
                  rsp_valid_d = 1'b1;
                  rsp_fault_d = 1'b1;
                  rsp_last_d  = 1'b1;
               end else begin
                  store_d = req_store;
                  byte_d  = req_byte;
                  base_d  = req_addr;
                  cnt_d   = req_count;
                  beat_d  = '0;
                  state_d = ST_ACCESS;
               end
            end
         end

         ST_ACCESS: begin
            mem_addr = beat_addr;
            if (store_q && !byte_q) begin
               mem_we    = 1'b1;
               mem_wdata = req_wdata;
            end
            if (store_q && byte_q && !mem_excpt) begin
               // Byte store: keep the old word and write the merged word next cycle
               rmw_d   = mem_rdata;
               state_d = ST_RMW_WR;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_idx_d   = beat_q;
               rsp_fault_d = mem_excpt;
               if (!store_q && !mem_excpt)
                  rsp_data_d = byte_q ? lane_ext : mem_rdata;
               if (mem_excpt || (beat_q == cnt_q)) begin
                  rsp_last_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  beat_d = beat_q + CW'(1);
               end
            end
         end

         ST_RMW_WR: begin
            mem_addr    = beat_addr;
            mem_we      = 1'b1;
            mem_wdata   = lane_merge;
            rsp_valid_d = 1'b1;
            rsp_idx_d   = beat_q;
            rsp_fault_d = mem_excpt;
            rsp_last_d  = 1'b1;
            state_d     = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_arm_lsu.sv
// Self-checking bench for arm_lsu with a small word memory at 0x10000000..0x100000FF.
module tb_arm_lsu;

   typedef struct packed {
      logic [3:0]  idx;
      logic [31:0] data;
      logic        fault;
      logic        last;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_store, req_byte;
   logic        req_ready;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_count, beat_idx;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_excpt;
   logic        rsp_valid, rsp_fault, rsp_last;
   logic [3:0]  rsp_idx;
   logic [31:0] rsp_data;

   logic [31:0] mem  [64];
   logic [31:0] wtbl [16];
   rsp_t        sbq  [$];
   logic        pend_we;
   logic [5:0]  pend_idx;
   logic [31:0] pend_data;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   assign mem_excpt = (mem_addr[31:8] != 24'h100000);
   assign mem_rdata = mem_excpt ? 32'd0 : mem[mem_addr[7:2]];
   assign req_wdata = wtbl[beat_idx];

   arm_lsu #(.BURST_MAX(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_byte(req_byte), .req_addr(req_addr), .req_count(req_count),
      .req_wdata(req_wdata), .beat_idx(beat_idx),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .mem_excpt(mem_excpt),
      .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_data(rsp_data),
      .rsp_fault(rsp_fault), .rsp_last(rsp_last)
   );

   // Memory write the model will commit at the coming rising edge
   task automatic sample_write();
      pend_we   = mem_we && !mem_excpt;
      pend_idx  = mem_addr[7:2];
      pend_data = mem_wdata;
   endtask

   // Advance to the next falling edge: commit memory write, score any response
   task automatic tick();
      rsp_t act, exp;
      @(negedge clk);
      if (pend_we) mem[pend_idx] = pend_data;
      pend_we = 1'b0;
      if (rsp_valid) begin
         act = {rsp_idx, rsp_data, rsp_fault, rsp_last};
         vectors++;
         if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL rsp_unexpected got idx=%0d data=%h fault=%b last=%b, wanted none", rsp_idx, rsp_data, rsp_fault, rsp_last);
         end else begin
            exp = sbq.pop_front();
            if (act !== exp) begin
               miscompares++;
               $display("FAIL rsp got idx=%0d data=%h fault=%b last=%b, wanted idx=%0d data=%h fault=%b last=%b",
                        act.idx, act.data, act.fault, act.last, exp.idx, exp.data, exp.fault, exp.last);
            end
         end
      end
      sample_write();
   endtask

   task automatic send(input logic st, input logic by, input logic [31:0] a, input logic [3:0] c);
      req_valid = 1'b1; req_store = st; req_byte = by; req_addr = a; req_count = c;
      tick();
      req_valid = 1'b0;
   endtask

   // Run until all expected responses are seen and the unit is idle, bounded
   task automatic drain();
      int n;
      n = 0;
      while ((sbq.size() != 0 || req_ready !== 1'b1) && n < 40) begin
         tick();
         n++;
      end
      vectors++;
      if (sbq.size() != 0 || req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL drain got pending=%0d ready=%b, wanted pending=0 ready=1", sbq.size(), req_ready);
         sbq.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_byte = 1'b0; req_addr = '0; req_count = '0;
      pend_we = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      for (int i = 0; i < 16; i++) wtbl[i] = 32'd0;
      #2;
      vectors++;
      if ({req_ready, mem_we, mem_addr, mem_wdata, beat_idx, rsp_valid, rsp_idx, rsp_data, rsp_fault, rsp_last}
          !== {1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_values got ready=%b we=%b addr=%h wdata=%h beat=%0d rv=%b", req_ready, mem_we, mem_addr, mem_wdata, beat_idx, rsp_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_word_load();
      mem[4] = 32'hDEADBEEF;
      sbq.push_back({4'd0, 32'hDEADBEEF, 1'b0, 1'b1});
      send(1'b0, 1'b0, 32'h10000010, 4'd0);
      vectors++;
      if ({mem_addr, mem_we, req_ready, rsp_valid} !== {32'h10000010, 1'b0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL wload_issue got addr=%h we=%b ready=%b rv=%b, wanted 10000010 0 0 0", mem_addr, mem_we, req_ready, rsp_valid);
      end
      tick();
      vectors++;
      if ({rsp_valid, req_ready} !== 2'b11) begin
         miscompares++;
         $display("FAIL wload_rsp_timing got rv=%b ready=%b, wanted 1 1", rsp_valid, req_ready);
      end
      drain();
   endtask

   task automatic test_byte_store();
      mem[0] = 32'h11223344;
      wtbl[0] = 32'hFFFFFFA5;
      sbq.push_back({4'd0, 32'd0, 1'b0, 1'b1});
      send(1'b1, 1'b1, 32'h10000002, 4'd0);
      vectors++;
      if ({mem_we, mem_addr} !== {1'b0, 32'h10000000}) begin
         miscompares++;
         $display("FAIL bstore_read got we=%b addr=%h, wanted 0 10000000", mem_we, mem_addr);
      end
      tick();
      vectors++;
      if ({mem_we, mem_addr, mem_wdata, rsp_valid} !== {1'b1, 32'h10000000, 32'h1122A544, 1'b0}) begin
         miscompares++;
         $display("FAIL bstore_write got we=%b addr=%h wdata=%h rv=%b, wanted 1 10000000 1122a544 0", mem_we, mem_addr, mem_wdata, rsp_valid);
      end
      tick();
      vectors++;
      if (rsp_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL bstore_rsp_timing got rv=%b, wanted 1", rsp_valid);
      end
      drain();
      vectors++;
      if (mem[0] !== 32'h1122A544) begin
         miscompares++;
         $display("FAIL bstore_mem got %h, wanted 1122a544", mem[0]);
      end
   endtask

   task automatic test_burst_fault();
      logic [31:0] exp_addr [3];
      exp_addr[0] = 32'h100000F8; exp_addr[1] = 32'h100000FC; exp_addr[2] = 32'h10000100;
      for (int i = 0; i < 4; i++) wtbl[i] = 32'hA0A0_0000 + 32'(i);
      sbq.push_back({4'd0, 32'd0, 1'b0, 1'b0});
      sbq.push_back({4'd1, 32'd0, 1'b0, 1'b0});
      sbq.push_back({4'd2, 32'd0, 1'b1, 1'b1});
      send(1'b1, 1'b0, 32'h100000F8, 4'd3);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if ({mem_addr, mem_we, mem_wdata} !== {exp_addr[k], 1'b1, wtbl[k]}) begin
            miscompares++;
            $display("FAIL burst_beat%0d got addr=%h we=%b wdata=%h, wanted %h 1 %h", k, mem_addr, mem_we, mem_wdata, exp_addr[k], wtbl[k]);
         end
         tick();
      end
      vectors++;
      if ({mem_we, mem_addr, req_ready} !== {1'b0, 32'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL burst_no_beat3 got we=%b addr=%h ready=%b, wanted 0 0 1", mem_we, mem_addr, req_ready);
      end
      drain();
      vectors++;
      if ({mem[62], mem[63]} !== {32'hA0A00000, 32'hA0A00001}) begin
         miscompares++;
         $display("FAIL burst_mem got %h %h, wanted a0a00000 a0a00001", mem[62], mem[63]);
      end
   endtask

   task automatic test_misaligned();
      sbq.push_back({4'd0, 32'd0, 1'b1, 1'b1});
      send(1'b0, 1'b0, 32'h10000001, 4'd0);
      vectors++;
      if ({rsp_valid, mem_we, mem_addr, req_ready} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL misaligned got rv=%b we=%b addr=%h ready=%b, wanted 1 0 0 1", rsp_valid, mem_we, mem_addr, req_ready);
      end
      sbq.push_back({4'd0, 32'd0, 1'b1, 1'b1});
      send(1'b1, 1'b1, 32'h10000000, 4'd2);
      vectors++;
      if ({rsp_valid, mem_we, req_ready} !== 3'b101) begin
         miscompares++;
         $display("FAIL illegal_byte_burst got rv=%b we=%b ready=%b, wanted 1 0 1", rsp_valid, mem_we, req_ready);
      end
      drain();
   endtask

   task automatic test_byte_load();
      logic [31:0] w, exp_b;
      w = 32'h11223344;
      mem[0] = w;
      for (int l = 0; l < 4; l++) begin
         exp_b = (w >> (24 - 8 * l)) & 32'h000000FF;
         sbq.push_back({4'd0, exp_b, 1'b0, 1'b1});
         send(1'b0, 1'b1, 32'h10000000 + 32'(l), 4'd0);
         drain();
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         mem[16 + i] = 32'h5500_0000 + 32'(i * 7);
         sbq.push_back({4'(i), 32'h5500_0000 + 32'(i * 7), 1'b0, (i == 3)});
      end
      send(1'b0, 1'b0, 32'h10000040, 4'd3);
      for (int i = 0; i < 4; i++) tick();
      vectors++;
      if ({rsp_last, req_ready} !== 2'b11) begin
         miscompares++;
         $display("FAIL b2b_last got last=%b ready=%b, wanted 1 1", rsp_last, req_ready);
      end
      mem[20] = 32'hCAFEF00D;
      sbq.push_back({4'd0, 32'hCAFEF00D, 1'b0, 1'b1});
      send(1'b0, 1'b0, 32'h10000050, 4'd0);
      vectors++;
      if ({mem_addr, req_ready} !== {32'h10000050, 1'b0}) begin
         miscompares++;
         $display("FAIL b2b_next got addr=%h ready=%b, wanted 10000050 0", mem_addr, req_ready);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) wtbl[i] = 32'hB0B0_0000 + 32'(i);
      sbq.push_back({4'd0, 32'd0, 1'b0, 1'b0});
      sbq.push_back({4'd1, 32'd0, 1'b0, 1'b0});
      send(1'b1, 1'b0, 32'h10000080, 4'd3);
      tick();
      tick();
      #1 rst = 1'b1;
      #1;
      sample_write();
      vectors++;
      if ({mem_we, rsp_valid, req_ready} !== 3'b001) begin
         miscompares++;
         $display("FAIL reset_mid got we=%b rv=%b ready=%b, wanted 0 0 1", mem_we, rsp_valid, req_ready);
      end
      tick();
      rst = 1'b0;
      tick();
      tick();
      vectors++;
      if ({mem[32], mem[33], mem[34], mem[35]} !== {32'hB0B00000, 32'hB0B00001, 32'd0, 32'd0}) begin
         miscompares++;
         $display("FAIL reset_mid_mem got %h %h %h %h, wanted b0b00000 b0b00001 0 0", mem[32], mem[33], mem[34], mem[35]);
      end
      sbq.push_back({4'd0, 32'hB0B00001, 1'b0, 1'b1});
      send(1'b0, 1'b0, 32'h10000084, 4'd0);
      drain();
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_store();
      test_burst_fault();
      test_misaligned();
      test_byte_load();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
